interrupt_ram_arbiter: RTL

Two-master arbiter placed in front of the 51200×32 single-port on-chip RAM (altsyncram, 16-bit word address, 4 byte lanes, one-cycle read latency). Shares the RAM's single port between an instruction/data requester (m0) and a second requester such as a DMA or debug master (m1), with Avalon-MM slave-side handshakes. Arbitration is round-robin with a bounded hold, so neither master can starve the other. Read data is steered back to the issuing master one cycle after its command is accepted.

---
 rtl/interrupt_ram_pkg.sv | 7 +
 rtl/rr_grant2.sv | 15 +
 rtl/interrupt_ram_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/interrupt_ram_pkg.sv
// interrupt_ram_pkg: shared constants and types for the two-master RAM arbiter
package interrupt_ram_pkg;
    localparam int NUM_MASTERS    = 2;
    localparam int RAM_RD_LATENCY = 1;
    localparam int RAM_DEPTH      = 51200;
    typedef logic [$clog2(NUM_MASTERS)-1:0] master_t;
endpackage

// File: rtl/rr_grant2.sv
// rr_grant2: two-way round-robin picker; hold_ok lets the previous winner keep a contended grant
module rr_grant2
    import interrupt_ram_pkg::*;
(
    input  logic [1:0] req,
    input  master_t    last,
    input  logic       hold_ok,
    output logic [1:0] grant
);
    master_t pick;
    always_comb begin
        pick  = (req == 2'b11) ? (hold_ok ? last : ~last) : master_t'(req[1]);
        grant = (req == 2'b00) ? 2'b00 : 2'b01 << pick;
    end
endmodule

// File: rtl/interrupt_ram_arbiter.sv
// interrupt_ram_arbiter: shares one single-port RAM between two Avalon-MM masters
// with round-robin bounded-hold arbitration and one-cycle read-return steering.
module interrupt_ram_arbiter
    import interrupt_ram_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int HOLD_MAX = 4
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);
    logic              blk, sel, hold_ok, rd_pend;
    logic [1:0]        req, grant;
    logic [3:0]        hold_cnt;
    master_t           last, rd_owner;
    logic [DATA_W-1:0] held0, held1;

    assign blk     = reset | reset_req;
    assign req     = blk ? 2'b00 : {m1_read | m1_write, m0_read | m0_write};
    // a zero count means the contender just arrived, so it must win rather than be held off
    assign hold_ok = (hold_cnt != 4'd0) && (hold_cnt < 4'(HOLD_MAX));

    rr_grant2 u_pick (.req(req), .last(last), .hold_ok(hold_ok), .grant(grant));

    always_comb begin
        sel              = grant[1];
        m0_waitrequest   = blk | (req[0] & ~grant[0]);
        m1_waitrequest   = blk | (req[1] & ~grant[1]);
        ram_chipselect   = |grant;
        ram_write        = sel ? m1_write : grant[0] & m0_write;
        ram_address      = sel ? m1_address : m0_address;
        ram_writedata    = sel ? m1_writedata : m0_writedata;
        ram_byteenable   = ram_write ? (sel ? m1_byteenable : m0_byteenable) : '1;
        ram_clken        = ~reset_req;
        m0_readdatavalid = rd_pend & ~rd_owner[0];
        m1_readdatavalid = rd_pend & rd_owner[0];
        m0_readdata      = m0_readdatavalid ? ram_readdata : held0;
        m1_readdata      = m1_readdatavalid ? ram_readdata : held1;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            last     <= 1'b1;
            hold_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_owner <= '0;
            held0    <= '0;
            held1    <= '0;
        end else begin
            rd_pend  <= ram_chipselect & ~ram_write;
            rd_owner <= sel;
            if (m0_readdatavalid) held0 <= ram_readdata;
            if (m1_readdatavalid) held1 <= ram_readdata;
            if (!reset_req) begin
                hold_cnt <= (req != 2'b11) ? 4'd0 : (sel == last[0]) ? hold_cnt + 4'd1 : 4'd1;
                if (|grant) last <= sel;
            end
        end
endmodule
